full_adder_unit: RTL and testbench

- Registered N-bit ripple-carry adder built from 1-bit full-adder cells; computes S, Cout = A + B + Cin.
- Default WIDTH=1 gives the classic single-bit full adder with a registered output stage.
- Arithmetic leaf block for datapaths needing a clean, clocked add with carry-in/carry-out and a valid qualifier.

---
 rtl/full_adder_pkg.sv | 8 +
 rtl/fa_bit.sv | 17 +
 rtl/full_adder_unit.sv | 56 +++++
 tb/tb_full_adder_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// Shared constants for the registered ripple-carry adder.
// Width bounds live here so the top and any wrapper agree on them.
package full_adder_pkg;

  localparam int FA_WIDTH_DEFAULT = 1;
  localparam int FA_WIDTH_MAX     = 64;

endpackage

// File: rtl/fa_bit.sv
// One-bit full-adder cell: s = a^b^cin, cout = majority(a,b,cin).
// Purely combinational, zero latency, no flow control.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/full_adder_unit.sv
// Registered N-bit ripple-carry adder with carry-in/out and signed overflow.
// Latency 1 cycle, throughput 1/cycle, no backpressure (in_valid gates capture).
module full_adder_unit
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic             ovf_c;

  assign carry[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_bit u_fa_bit (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  // Carry into the MSB differs from carry out only on two's-complement overflow.
  assign ovf_c = carry[WIDTH] ^ carry[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S         <= '0;
      Cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Data registers only load on valid, so junk on idle inputs never lands in S.
      if (in_valid) begin
        S    <= sum;
        Cout <= carry[WIDTH];
        ovf  <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_full_adder_unit.sv
// Directed bench for full_adder_unit at WIDTH=1 and WIDTH=8, plus a random back-to-back run.
module tb_full_adder_unit;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       a1, b1, cin1, iv1;
  logic       s1, cout1, ovf1, ov1;

  logic [7:0] a8, b8;
  logic       cin8, iv8;
  logic [7:0] s8;
  logic       cout8, ovf8, ov8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  full_adder_unit #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (a1),
    .B         (b1),
    .Cin       (cin1),
    .in_valid  (iv1),
    .S         (s1),
    .Cout      (cout1),
    .ovf       (ovf1),
    .out_valid (ov1)
  );

  full_adder_unit #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (a8),
    .B         (b8),
    .Cin       (cin8),
    .in_valid  (iv8),
    .S         (s8),
    .Cout      (cout8),
    .ovf       (ovf8),
    .out_valid (ov8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] es, input logic ec,
                      input logic eo, input logic ev);
    chk({tag, ".S"}, 64'(s8), 64'(es));
    chk({tag, ".Cout"}, 64'(cout8), 64'(ec));
    chk({tag, ".ovf"}, 64'(ovf8), 64'(eo));
    chk({tag, ".out_valid"}, 64'(ov8), 64'(ev));
  endtask

  task automatic chk1(input string tag, input logic es, input logic ec,
                      input logic eo, input logic ev);
    chk({tag, ".S"}, 64'(s1), 64'(es));
    chk({tag, ".Cout"}, 64'(cout1), 64'(ec));
    chk({tag, ".ovf"}, 64'(ovf1), 64'(eo));
    chk({tag, ".out_valid"}, 64'(ov1), 64'(ev));
  endtask

  // Hand-computed truth table for vector i = {A,B,Cin}; bit i holds the expected value.
  logic [7:0] exp_s1   = 8'b1001_0110;
  logic [7:0] exp_c1   = 8'b1110_1000;
  logic [7:0] exp_ovf1 = 8'b0100_0010;

  initial begin
    logic [2:0] v;
    logic [8:0] sum9;
    logic       e_ovf;

    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; iv1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; iv8 = 1'b0;
    #12;
    chk1("reset1", 1'b0, 1'b0, 1'b0, 1'b0);
    chk8("reset8", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    // WIDTH=1 exhaustive
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; iv1 = 1'b1;
      step();
      chk1($sformatf("w1_vec%0d", i), exp_s1[i], exp_c1[i], exp_ovf1[i], 1'b1);
    end

    // Hold: valid 1+1+0 then idle with different operands
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0; iv1 = 1'b1;
    step();
    chk1("hold_load", 1'b0, 1'b1, 1'b1, 1'b1);
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b1; iv1 = 1'b0;
    step();
    chk1("hold_idle", 1'b0, 1'b1, 1'b1, 1'b0);
    a1 = 1'bx; b1 = 1'bx; cin1 = 1'bx;
    step();
    chk1("hold_xin", 1'b0, 1'b1, 1'b1, 1'b0);

    // Inputs changing between edges must not disturb registered outputs
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; iv1 = 1'b1;
    step();
    chk1("midcyc_load", 1'b1, 1'b0, 1'b0, 1'b1);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    #3;
    chk1("midcyc_hold", 1'b1, 1'b0, 1'b0, 1'b1);
    iv1 = 1'b0;

    // WIDTH=8 boundaries
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; iv8 = 1'b1;
    step();
    chk8("w8_zero", 8'h00, 1'b0, 1'b0, 1'b1);
    a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1;
    step();
    chk8("w8_ripple", 8'h00, 1'b1, 1'b0, 1'b1);
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
    step();
    chk8("w8_posovf", 8'h80, 1'b0, 1'b1, 1'b1);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    step();
    chk8("w8_negovf", 8'h00, 1'b1, 1'b1, 1'b1);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    step();
    chk8("w8_allones", 8'hFF, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle after a valid result
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1;
    step();
    chk8("pre_rst", 8'h47, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk8("async_rst8", 8'h00, 1'b0, 1'b0, 1'b0);
    chk1("async_rst1", 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b1;
    iv8 = 1'b0;
    step();
    chk8("post_rst_idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // Back-to-back random adds
    for (int i = 0; i < 1000; i++) begin
      a8   = 8'($urandom_range(0, 255));
      b8   = 8'($urandom_range(0, 255));
      cin8 = 1'($urandom_range(0, 1));
      iv8  = 1'b1;
      sum9  = {1'b0, a8} + {1'b0, b8} + {8'h00, cin8};
      e_ovf = (a8[7] == b8[7]) && (sum9[7] != a8[7]);
      step();
      chk8($sformatf("rnd%0d", i), sum9[7:0], sum9[8], e_ovf, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
